// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Pipeline-side initiator for data memory accesses. Decodes a load/store from
// the MEM stage, rejects misaligned accesses, issues one word-aligned request
// with byte enables on a req/ack bus, and returns the extracted and
// sign/zero-extended load result. A timeout aborts a request that is never
// acknowledged.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   MemRead, MemWrite   access request from control (write has priority)
//   Funct3              access size / signedness
//   addr, wdata         byte address and store data
//   stall               freeze pipeline (combinational)
//   rdata, rdata_valid  load result and its one-cycle valid pulse
//   misaligned          one-cycle pulse, access rejected
//   bus_err             one-cycle pulse, request aborted by timeout
//   m_req .. m_wdata    memory request channel (held stable until m_ack)
//   m_ack, m_rdata      memory response
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              misaligned,
  output logic              bus_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_be,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counter value during the last permitted REQ cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_size;
  logic              r_sgn;
  logic [1:0]        r_off;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_valid;
  logic              r_err;

  logic              w_access;
  logic [1:0]        w_size;
  logic              w_sgn;
  logic              w_mis;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;

  // Select the addressed lane of the returned word and extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> {off, 3'b000};
    case (size)
      SZ_B:    res = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SZ_H:    res = off[1] ? {{16{sgn & word[31]}}, word[31:16]}
                            : {{16{sgn & word[15]}}, word[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Decode size/signedness, alignment, byte enables and store lanes.
  always_comb begin
    w_access = MemRead | MemWrite;
    w_size   = SZ_W;
    w_sgn    = 1'b0;
    if (MemWrite) begin
      case (Funct3)
        3'b000:  w_size = SZ_B;
        3'b001:  w_size = SZ_H;
        default: w_size = SZ_W;
      endcase
    end else begin
      case (Funct3)
        3'b000:  begin w_size = SZ_B; w_sgn = 1'b1; end
        3'b001:  begin w_size = SZ_H; w_sgn = 1'b1; end
        3'b100:  w_size = SZ_B;
        3'b101:  w_size = SZ_H;
        default: w_size = SZ_W;
      endcase
    end

    case (w_size)
      SZ_B: begin
        w_mis   = 1'b0;
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      SZ_H: begin
        w_mis   = addr[0];
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_mis   = (addr[1:0] != 2'b00);
        w_be    = 4'b1111;
        w_wdata = wdata;
      end
    endcase
  end

  // stall and misaligned must react in the same cycle the access is presented.
  assign stall       = (r_state == S_REQ) |
                       ((r_state == S_IDLE) & w_access & ~w_mis);
  assign misaligned  = (r_state == S_IDLE) & w_access & w_mis;
  assign m_req       = (r_state == S_REQ);
  assign m_we        = r_we;
  assign m_addr      = r_addr;
  assign m_be        = r_be;
  assign m_wdata     = r_wdata;
  assign rdata       = r_rdata;
  assign rdata_valid = r_valid;
  assign bus_err     = r_err;

  // Request FSM with timeout counter and registered response flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_size  <= SZ_B;
      r_sgn   <= 1'b0;
      r_off   <= 2'b00;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'b0000;
      r_wdata <= '0;
      r_rdata <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          r_err   <= 1'b0;
          if (w_access && !w_mis) begin
            r_we    <= MemWrite;
            r_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_size  <= w_size;
            r_sgn   <= w_sgn;
            r_off   <= addr[1:0];
            r_cnt   <= '0;
            r_state <= S_REQ;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          // An ack in the final permitted cycle wins over the abort.
          if (m_ack) begin
            if (!r_we) begin
              r_rdata <= extract_load(m_rdata, r_off, r_size, r_sgn);
            end else begin
              r_rdata <= r_rdata;
            end
            r_valid <= ~r_we;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_rdata <= '0;
            r_valid <= ~r_we;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // The stalled instruction is still on the inputs here; ignore it.
          r_valid <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for data memory accesses. Takes a load/store from the MEM stage (MemRead/MemWrite, Funct3, ALU address, store data), checks alignment, and issues one word-aligned request with byte enables on a req/ack memory bus. It stalls the pipeline while the request is outstanding. For loads, it extracts the addressed byte, halfword or word from the returned word and sign- or zero-extends it. A timeout guards against a responder that never acknowledges.

## Interface
Parameters:
- ADDR_W, 9, byte-address width (ALU output LSBs)
- DATA_W, 32, data width; only 32 is supported
- TIMEOUT, 15, maximum number of REQ cycles without m_ack before abort

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- MemRead  in  1  load request from control unit
- MemWrite  in  1  store request from control unit
- Funct3  in  3  instruction bits 14:12
- addr  in  ADDR_W  byte address
- wdata  in  32  store data (rs2)
- stall  out  1  freeze pipeline
- rdata  out  32  aligned, extended load result
- rdata_valid  out  1  one-cycle pulse; rdata valid
- misaligned  out  1  one-cycle pulse; access rejected
- bus_err  out  1  one-cycle pulse; timeout abort
- m_req  out  1  memory request
- m_we  out  1  1 = write
- m_addr  out  ADDR_W  word address; bits 1:0 always 0
- m_be  out  4  byte enables
- m_wdata  out  32  lane-replicated store data
- m_ack  in  1  responder accepts/completes request
- m_rdata  in  32  read word; valid when m_ack=1

## Operation
- FSM states: IDLE, REQ, DONE.
- Access decoding:
  - MemWrite has priority when both MemWrite and MemRead are high.
  - Load Funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 act as LW.
  - Store Funct3: 000 SB, 001 SH; all others act as SW.
- Misalignment:
  - A halfword access with addr[0]=1 is misaligned.
  - A word access with addr[1:0]≠0 is misaligned.
  - In IDLE, a misaligned access pulses misaligned for that cycle, does not assert stall, and issues no request. State stays IDLE.
- Accepting a request, in IDLE with an aligned access:
  - Register m_we, m_addr = {addr[ADDR_W-1:2],2'b00}, m_be, m_wdata, size and signedness, addr[1:0].
  - Go to REQ and clear the timeout counter.
- m_be:
  - Byte: 1<<addr[1:0].
  - Half: addr[1] ? 1100 : 0011.
  - Word: 1111.
  - Loads drive the same byte-enable pattern as stores.
- m_wdata:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- REQ state:
  - m_req=1; m_addr, m_be, m_we and m_wdata stay stable until m_ack.
  - When m_ack is sampled high, the request completes. For loads, rdata is captured from the lane selected by addr[1:0], sign-extended for LB/LH and zero-extended for LBU/LHU/LW. Go to DONE.
  - If the counter reaches TIMEOUT without m_ack, the request aborts: rdata is set to 0, bus_err is flagged, and the FSM goes to DONE.
- DONE state:
  - stall=0. rdata_valid=1 for loads. bus_err=1 if the request aborted.
  - New requests are ignored in this cycle; the stalled instruction is still presented. Return to IDLE.
- m_ack is ignored in IDLE and DONE.
- rdata holds its value until the next completed load or abort.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, counter 0. All outputs are 0, including stall, m_req, rdata, rdata_valid, misaligned, bus_err, m_be, m_addr and m_wdata.
- stall is combinational:
  - High in IDLE when an aligned access is presented.
  - High throughout REQ.
  - Low in DONE.
- Latency: with m_ack in the first REQ cycle, stall is high for 2 cycles (IDLE and REQ) and DONE follows on cycle 3. Each extra wait cycle adds one.
- Timeout: the abort occurs on the edge ending the TIMEOUT-th REQ cycle. m_req is high for exactly TIMEOUT cycles. An m_ack in that same cycle wins over the abort.
- Reset asserted mid-REQ: the next edge returns to IDLE, drops m_req, and produces no valid/err pulse. A pending m_ack is discarded.
- Back-to-back accesses: the second access is accepted in the IDLE cycle after DONE.

## Test plan
- LB at addr=0x0D, m_rdata=0x80FF_7F00, ack after 2 wait cycles -> m_be=0010, m_addr=0x0C; rdata=0x0000_007F; stall high 4 cycles; single rdata_valid pulse.
- LH at addr=0x0E, m_rdata=0x8001_0000 -> rdata=0xFFFF_8001. LHU at the same address -> rdata=0x0000_8001.
- SB at addr=0x03, wdata=0x1234_56AB -> m_we=1, m_be=1000, m_wdata=0xABAB_ABAB. SH at 0x02 -> m_be=1100, m_wdata=0x56AB_56AB.
- LW at addr=0x06 -> misaligned pulse, m_req never asserted, stall=0. SH at 0x01 behaves the same.
- LW with m_ack held low, TIMEOUT=15 -> m_req high for 15 cycles, then bus_err pulse and rdata=0. Repeat with m_ack in cycle 15 -> normal completion, no bus_err.
- rst_n low during the 2nd REQ cycle of an SW -> m_req=0 after the edge, no pulses. A new LW after reset completes normally.
